quad_encoder_reader: RTL and testbench

//  Reads the quadrature encoder pair returned by one drive motor (A/B on the PMOD input header) and

---
 rtl/quad_encoder_reader.sv | 199 +++++++++++++++++++
 tb/tb_quad_encoder_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_reader.sv
// quad_encoder_reader
// Decodes one motor's quadrature A/B pair into a signed position count, a
// per-window speed sample and a direction flag. Channel inputs are
// asynchronous: they pass through a two-flop synchroniser and a stability
// filter before the decode register sees them.
//
// state | meaning
// ------+---------------------------------------------------------------
// PRIME | waiting for the first filtered A/B value; it is loaded silently
// RUN   | every filtered A/B change is decoded into a step or an error
module quad_encoder_reader #(
    parameter int FILTER_LEN    = 4,
    parameter int POS_WIDTH     = 32,
    parameter int SPEED_WIDTH   = 16,
    parameter int SAMPLE_CYCLES = 1000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enc_a,
    input  logic                          enc_b,
    input  logic                          invert_dir,
    input  logic                          clear_pos,
    output logic signed [POS_WIDTH-1:0]   position,
    output logic signed [SPEED_WIDTH-1:0] speed,
    output logic                          speed_valid,
    output logic                          dir,
    output logic [7:0]                    err_count
);

    localparam int STAB_W = $clog2(FILTER_LEN + 1);
    localparam int WIN_W  = $clog2(SAMPLE_CYCLES);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILTER_LEN - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SAMPLE_CYCLES - 1);

    localparam logic signed [SPEED_WIDTH:0] ACC_MAX = {2'b00, {(SPEED_WIDTH-1){1'b1}}};
    localparam logic signed [SPEED_WIDTH:0] ACC_MIN = -ACC_MAX;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t state;

    logic a_meta, a_sync, b_meta, b_sync;
    logic [1:0] synced;

    logic [1:0]        cand;
    logic [1:0]        filt;
    logic [1:0]        filt_old;
    logic              filt_vld;
    logic [STAB_W-1:0] stab_cnt;
    logic [STAB_W-1:0] stab_next;
    logic              accept;

    logic              fwd, rev, illegal;
    logic              step_en;
    logic              step_up;
    logic              err_ev;
    logic signed [1:0] step;

    logic [WIN_W-1:0]              win_cnt;
    logic signed [SPEED_WIDTH-1:0] acc;
    logic signed [SPEED_WIDTH:0]   acc_sum;
    logic signed [SPEED_WIDTH:0]   acc_clamp;
    logic signed [SPEED_WIDTH-1:0] acc_sat;

    assign synced = {a_sync, b_sync};

    // Two-flop synchroniser on each asynchronous encoder channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_meta <= 1'b0;
            a_sync <= 1'b0;
            b_meta <= 1'b0;
            b_sync <= 1'b0;
        end else begin
            a_meta <= enc_a;
            a_sync <= a_meta;
            b_meta <= enc_b;
            b_sync <= b_meta;
        end
    end

    // Stability count for the current candidate; accept on the FILTER_LEN-th sample.
    always_comb begin
        stab_next = '0;
        if (synced == cand) begin
            stab_next = stab_cnt + STAB_W'(1);
        end
        accept = (synced != filt) && (stab_next == STAB_LAST);
    end

    // Filter register: filt only moves once a new value has held long enough.
    always_ff @(posedge clk) begin
        if (reset) begin
            cand     <= 2'b00;
            filt     <= 2'b00;
            filt_old <= 2'b00;
            filt_vld <= 1'b0;
            stab_cnt <= '0;
        end else begin
            cand     <= synced;
            filt_vld <= accept;
            if (accept) begin
                filt     <= synced;
                filt_old <= filt;
                stab_cnt <= '0;
            end else if (synced == filt) begin
                stab_cnt <= '0;
            end else begin
                stab_cnt <= stab_next;
            end
        end
    end

    // Classify the last accepted transition and form the signed step.
    always_comb begin
        fwd     = 1'b0;
        rev     = 1'b0;
        illegal = 1'b0;
        case ({filt_old, filt})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd     = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: rev     = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
            default: ;
        endcase
        step_en = filt_vld && (state == RUN) && (fwd || rev);
        err_ev  = filt_vld && (state == RUN) && illegal;
        step_up = fwd ^ invert_dir;
        step    = 2'sb00;
        if (step_en) begin
            step = step_up ? 2'sb01 : 2'sb11;
        end
    end

    // Decode FSM: priming, position accumulation, direction and error count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PRIME;
            position  <= '0;
            dir       <= 1'b0;
            err_count <= 8'd0;
        end else begin
            case (state)
                PRIME: if (filt_vld) state <= RUN;
                RUN:   state <= RUN;
                default: state <= PRIME;
            endcase
            // Clear wins over the old value but not over a same-cycle step.
            if (clear_pos) begin
                position <= {{(POS_WIDTH-2){step[1]}}, step};
            end else begin
                position <= position + {{(POS_WIDTH-2){step[1]}}, step};
            end
            if (step_en) begin
                dir <= step_up;
            end
            if (err_ev && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    // Saturating window accumulator including the step of the current cycle.
    always_comb begin
        acc_sum   = {acc[SPEED_WIDTH-1], acc} + {{(SPEED_WIDTH-1){step[1]}}, step};
        acc_clamp = acc_sum;
        if (acc_sum > ACC_MAX) begin
            acc_clamp = ACC_MAX;
        end else if (acc_sum < ACC_MIN) begin
            acc_clamp = ACC_MIN;
        end
        acc_sat = acc_clamp[SPEED_WIDTH-1:0];
    end

    // Speed window: publish the closing window (terminal-cycle step included) and restart.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt     <= '0;
            acc         <= '0;
            speed       <= '0;
            speed_valid <= 1'b0;
        end else begin
            speed_valid <= 1'b0;
            if (win_cnt == WIN_LAST) begin
                win_cnt     <= '0;
                acc         <= '0;
                speed       <= acc_sat;
                speed_valid <= 1'b1;
            end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                acc     <= acc_sat;
            end
        end
    end

endmodule

// File: tb/tb_quad_encoder_reader.sv
// Directed bench for quad_encoder_reader with an 8-bit position counter and
// a 100-cycle speed window so wrap-around and window edges are reachable.
module tb_quad_encoder_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        enc_a;
    logic        enc_b;
    logic        invert_dir;
    logic        clear_pos;
    logic [7:0]  position;
    logic [15:0] speed;
    logic        speed_valid;
    logic        dir;
    logic [7:0]  err_count;

    int errors = 0;
    int checks = 0;

    logic [1:0] cur;
    logic [7:0] exp_pos;

    quad_encoder_reader #(
        .FILTER_LEN   (4),
        .POS_WIDTH    (8),
        .SPEED_WIDTH  (16),
        .SAMPLE_CYCLES(100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .invert_dir (invert_dir),
        .clear_pos  (clear_pos),
        .position   (position),
        .speed      (speed),
        .speed_valid(speed_valid),
        .dir        (dir),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v);
        cur   = v;
        enc_a = v[1];
        enc_b = v[0];
    endtask

    function automatic logic [1:0] fwd_of(input logic [1:0] v);
        case (v)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // Advance to the cycle in which speed_valid is high (bounded).
    task automatic wait_sv(output bit found);
        found = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick(1);
            if (speed_valid) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; invert_dir = 1'b0; clear_pos = 1'b0;
        drive(2'b11);
        tick(3);
        checks++; if (position !== 8'd0) begin errors++; $display("FAIL reset_position got=%0h want=0", position); end
        checks++; if (speed !== 16'd0) begin errors++; $display("FAIL reset_speed got=%0h want=0", speed); end
        checks++; if (speed_valid !== 1'b0) begin errors++; $display("FAIL reset_speed_valid got=%b want=0", speed_valid); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir got=%b want=0", dir); end
        reset = 1'b0;
        tick(12);
        checks++; if (position !== 8'd0) begin errors++; $display("FAIL prime_position got=%0h want=0", position); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL prime_err got=%0d want=0", err_count); end
        exp_pos = 8'd0;
    endtask

    task automatic test_forward;
        drive(fwd_of(cur));
        tick(6);
        checks++; if (position !== 8'd0) begin errors++; $display("FAIL latency_early got=%0h want=0", position); end
        tick(1);
        checks++; if (position !== 8'd1) begin errors++; $display("FAIL latency_edge got=%0h want=1", position); end
        tick(3);
        for (int i = 0; i < 7; i++) begin
            drive(fwd_of(cur));
            tick(10);
        end
        checks++; if (position !== 8'd8) begin errors++; $display("FAIL fwd_position got=%0h want=8", position); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL fwd_dir got=%b want=1", dir); end

        clear_pos = 1'b1; tick(1); clear_pos = 1'b0;
        invert_dir = 1'b1;
        tick(2);
        for (int i = 0; i < 8; i++) begin
            drive(fwd_of(cur));
            tick(10);
        end
        exp_pos = 8'hF8;
        checks++; if (position !== exp_pos) begin errors++; $display("FAIL inv_position got=%0h want=%0h", position, exp_pos); end
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL inv_dir got=%b want=0", dir); end
    endtask

    task automatic test_filter_illegal;
        logic [1:0] rest;
        rest = cur;
        drive(rest ^ 2'b10);
        tick(3);
        drive(rest);
        tick(4);
        checks++; if (position !== exp_pos) begin errors++; $display("FAIL glitch_position got=%0h want=%0h", position, exp_pos); end
        tick(6);
        checks++; if (dir !== 1'b0) begin errors++; $display("FAIL glitch_dir got=%b want=0", dir); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL glitch_err got=%0d want=0", err_count); end

        invert_dir = 1'b0;
        tick(2);
        while (cur != 2'b00) begin
            drive(fwd_of(cur));
            exp_pos = exp_pos + 8'd1;
            tick(10);
        end
        checks++; if (position !== exp_pos) begin errors++; $display("FAIL pre_jump_position got=%0h want=%0h", position, exp_pos); end
        drive(2'b11);
        tick(10);
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL jump_err got=%0d want=1", err_count); end
        checks++; if (position !== exp_pos) begin errors++; $display("FAIL jump_position got=%0h want=%0h", position, exp_pos); end
        checks++; if (dir !== 1'b1) begin errors++; $display("FAIL jump_dir got=%b want=1", dir); end

        for (int i = 0; i < 260; i++) begin
            drive(cur ^ 2'b11);
            tick(6);
        end
        tick(4);
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL err_saturate got=%0d want=255", err_count); end
        checks++; if (position !== exp_pos) begin errors++; $display("FAIL sat_position got=%0h want=%0h", position, exp_pos); end
    endtask

    task automatic test_window;
        bit found;
        int sv_cnt;
        wait_sv(found);
        checks++; if (!found) begin errors++; $display("FAIL window_sync got=timeout want=speed_valid"); end
        for (int i = 0; i < 5; i++) begin
            drive(fwd_of(cur));
            exp_pos = exp_pos + 8'd1;
            tick(10);
        end
        sv_cnt = 0;
        for (int k = 0; k < 49; k++) begin
            tick(1);
            if (speed_valid) sv_cnt++;
        end
        checks++; if (sv_cnt !== 0) begin errors++; $display("FAIL window_early_pulse got=%0d want=0", sv_cnt); end
        tick(1);
        checks++; if (speed_valid !== 1'b1) begin errors++; $display("FAIL window_valid got=%b want=1", speed_valid); end
        checks++; if (speed !== 16'd5) begin errors++; $display("FAIL window_speed got=%0d want=5", speed); end
        tick(1);
        checks++; if (speed_valid !== 1'b0) begin errors++; $display("FAIL window_pulse_width got=%b want=0", speed_valid); end
        tick(9);
        drive(fwd_of(cur));
        tick(83);
        drive(fwd_of(cur));
        tick(7);
        exp_pos = exp_pos + 8'd2;
        checks++; if (speed !== 16'd2) begin errors++; $display("FAIL terminal_step_speed got=%0d want=2", speed); end
        tick(3);
        drive(fwd_of(cur));
        exp_pos = exp_pos + 8'd1;
        tick(97);
        checks++; if (speed !== 16'd1) begin errors++; $display("FAIL next_window_speed got=%0d want=1", speed); end
        checks++; if (position !== exp_pos) begin errors++; $display("FAIL window_position got=%0h want=%0h", position, exp_pos); end
    endtask

    task automatic test_wrap_clear;
        clear_pos = 1'b1; tick(1); clear_pos = 1'b0;
        tick(2);
        for (int i = 0; i < 127; i++) begin
            drive(fwd_of(cur));
            tick(6);
        end
        tick(4);
        checks++; if (position !== 8'h7F) begin errors++; $display("FAIL pos_max got=%0h want=7f", position); end
        drive(fwd_of(cur));
        tick(10);
        checks++; if (position !== 8'h80) begin errors++; $display("FAIL pos_wrap got=%0h want=80", position); end
        drive(fwd_of(cur));
        tick(6);
        checks++; if (position !== 8'h80) begin errors++; $display("FAIL pre_clear got=%0h want=80", position); end
        clear_pos = 1'b1;
        tick(1);
        clear_pos = 1'b0;
        checks++; if (position !== 8'h01) begin errors++; $display("FAIL clear_with_step got=%0h want=1", position); end
        tick(5);
    endtask

    task automatic test_reset_mid_window;
        bit found;
        int sv_cnt;
        if (cur == 2'b00) begin
            drive(fwd_of(cur));
            tick(10);
        end
        wait_sv(found);
        checks++; if (!found) begin errors++; $display("FAIL reset_sync got=timeout want=speed_valid"); end
        for (int i = 0; i < 3; i++) begin
            drive(fwd_of(cur));
            tick(10);
        end
        if (cur == 2'b00) begin
            drive(fwd_of(cur));
            tick(10);
        end
        tick(10);
        reset = 1'b1;
        tick(2);
        checks++; if (speed !== 16'd0) begin errors++; $display("FAIL midreset_speed got=%0d want=0", speed); end
        checks++; if (speed_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got=%b want=0", speed_valid); end
        checks++; if (position !== 8'd0) begin errors++; $display("FAIL midreset_position got=%0h want=0", position); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL midreset_err got=%0d want=0", err_count); end
        reset = 1'b0;
        sv_cnt = 0;
        for (int k = 0; k < 10; k++) begin tick(1); if (speed_valid) sv_cnt++; end
        drive(fwd_of(cur));
        for (int k = 0; k < 10; k++) begin tick(1); if (speed_valid) sv_cnt++; end
        drive(fwd_of(cur));
        for (int k = 0; k < 79; k++) begin tick(1); if (speed_valid) sv_cnt++; end
        checks++; if (sv_cnt !== 0) begin errors++; $display("FAIL postreset_early_pulse got=%0d want=0", sv_cnt); end
        tick(1);
        checks++; if (speed_valid !== 1'b1) begin errors++; $display("FAIL postreset_valid got=%b want=1", speed_valid); end
        checks++; if (speed !== 16'd2) begin errors++; $display("FAIL postreset_speed got=%0d want=2", speed); end
        checks++; if (position !== 8'd2) begin errors++; $display("FAIL postreset_position got=%0h want=2", position); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_filter_illegal();
        test_window();
        test_wrap_clear();
        test_reset_mid_window();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
